rf_exec_stage: RTL and testbench
================================

// Module: rf_exec_stage
// PURPOSE
//   Two-stage execute/writeback pipeline that sits in front of the 4x16 register file.
//   It accepts one instruction per cycle over a valid/ready handshake and drives the
//   file's two read ports (rdAddrA/B). It computes a 16-bit ALU result and drives the
//   file's write port (write/wrAddr/wrData). Operand forwarding hides the write latency.
// PARAMETERS
//   DW    16  data width; matches register-file entry width
//   AW    3   register address width; matches register-file address ports
//   NREG  4   number of implemented registers; addresses >= NREG read as 0, never written
// PORTS
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   instruction present
//   in_ready   out  1   block accepts instruction; = !stall
//   in_op      in   3   opcode (see package)
//   in_rd      in   AW  destination register
//   in_rsa     in   AW  source A register
//   in_rsb     in   AW  source B register
//   in_imm     in   DW  immediate (LDI only)
//   stall      in   1   upstream hold request; blocks accept, pipeline still drains
//   rdAddrA    out  AW  to register file; combinational = in_rsa
//   rdDataA    in   DW  from register file, combinational read
//   rdAddrB    out  AW  to register file; combinational = in_rsb
//   rdDataB    in   DW  from register file
//   write      out  1   register-file write enable (registered)
//   wrAddr     out  AW  register-file write address (registered)
//   wrData     out  DW  register-file write data (registered)
//   carry      out  1   carry/borrow of last retired ADD/SUB (registered)
//   zero       out  1   last retired result == 0 (registered)
//   retired    out  16  count of retired instructions, wraps at 0xFFFF->0
// BEHAVIOUR
// - Accept: in_valid & in_ready at rising edge N. S1 captures op, rd, imm and the
//   forwarded operands A and B.
// - S1 (cycle N+1): the ALU evaluates combinationally. WB regs capture the result at
//   edge N+1.
// - WB (cycle N+2): write=1, wrAddr=rd, wrData=result. The file updates at edge N+2.
//   Accept-to-write latency is 2 cycles. Throughput is 1 per cycle.
// - Forwarding per source (priority high->low):
//   (1) source >= NREG -> 0.
//   (2) S1 valid and S1.rd == source and S1.rd < NREG -> S1 ALU result.
//   (3) WB write and wrAddr == source -> wrData.
//   (4) otherwise -> rdData.
// - Ops:
//   ADD=0  A+B, carry=bit16
//   SUB=1  A-B, carry=borrow
//   AND=2
//   OR=3
//   XOR=4
//   SHL=5  A<<B[3:0]
//   SHR=6  logical A>>B[3:0]
//   LDI=7  imm
//   All results are truncated to DW.
// - Flags:
//   carry updates only for ADD/SUB and holds otherwise.
//   zero updates for every retired op.
//   Both flags update at the WB edge.
// - rd >= NREG: the instruction flows and retires (counter++, zero updates). write stays
//   0 in its WB cycle.
// - stall:
//   in_ready=0 combinationally and nothing is accepted.
//   S1/WB continue, so a stalled pipe empties in 2 cycles.
// - Bubbles (no accept): S1 valid=0 next cycle. write=0 in the corresponding WB cycle.
// - Reset (async, any time):
//   S1/WB valid=0, write=0, wrAddr=0, wrData=0, carry=0, zero=0, retired=0.
//   In-flight instructions are dropped, and no write occurs after release.
//   in_ready follows stall even during reset. Nothing is captured while rst_n=0.
// STRUCTURE
// - Package rf_pkg holds:
//   opcode localparams OP_ADD..OP_LDI, DW/AW/NREG defaults, and an instruction struct
//   {op, rd, rsa, rsb, imm}.
// - One sub-module: rf_alu (combinational; op, a, b, imm -> result[DW-1:0], carry).
// - Forward mux and pipeline regs stay in rf_exec_stage.
// TESTING
// 1. LDI r1,0x1234 accepted at cycle 0 -> cycle 2: write=1, wrAddr=1, wrData=0x1234;
//    retired=1, zero=0.
// 2. Back-to-back LDI r0,5 then ADD r2,r0,r0 -> ADD's WB: wrData=0x000A (S1 forward).
//    Same with one bubble between -> 0x000A (WB forward). Same with two bubbles
//    -> 0x000A (file read).
// 3. LDI r0,0 then SUB r3,r0,r1 where r1=1 -> wrData=0xFFFF, carry=1, zero=0.
//    Then XOR r3,r3,r3 -> wrData=0, zero=1, carry holds 1.
// 4. LDI r5,0x00FF -> write stays 0 in its WB cycle, retired increments.
//    Then ADD r0,r5,r5 -> wrData=0 (source >= NREG reads 0, no forward).
// 5. stall=1 with in_valid=1 for 3 cycles -> in_ready=0, no accept.
//    Pipe drains: the last pre-stall write appears, then write=0.
//    Release -> accept resumes the same cycle.
// 6. rst_n low for 1 cycle while S1 and WB are both valid -> write=0 immediately, flags
//    and retired=0. No write for the next 2 cycles after release when in_valid=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared opcodes, default geometry and the instruction bundle for the execute/writeback stage.
package rf_pkg;
  localparam int RF_DW   = 16;
  localparam int RF_AW   = 3;
  localparam int RF_NREG = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  typedef struct packed {
    logic [2:0]       op;
    logic [RF_AW-1:0] rd;
    logic [RF_AW-1:0] rsa;
    logic [RF_AW-1:0] rsb;
    logic [RF_DW-1:0] imm;
  } instr_t;

  // Only ADD/SUB produce a carry/borrow; every other op leaves the flag alone.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction
endpackage

// File: rtl/rf_alu.sv
// Combinational 16-bit ALU for the execute stage; zero latency, no flow control.
module rf_alu
  import rf_pkg::*;
#(
  parameter int DW = RF_DW
) (
  input  logic [2:0]    op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] imm_i,
  output logic [DW-1:0] result_o,
  output logic          carry_o
);
  logic [DW:0] sum;
  logic [DW:0] diff;

  // The extra top bit is the carry-out for ADD and the borrow for SUB.
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = sum[DW-1:0];
        carry_o  = sum[DW];
      end
      OP_SUB: begin
        result_o = diff[DW-1:0];
        carry_o  = diff[DW];
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SHL:  result_o = a_i << b_i[3:0];
      OP_SHR:  result_o = a_i >> b_i[3:0];
      OP_LDI:  result_o = imm_i;
      default: result_o = '0;
    endcase
  end
endmodule

// File: rtl/rf_exec_stage.sv
// Execute/writeback pipeline in front of the register file; accept-to-write latency 2, 1/cycle.
// stall drops in_ready combinationally while S1/WB keep draining.
module rf_exec_stage
  import rf_pkg::*;
#(
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW,
  parameter int NREG = RF_NREG
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rsa,
  input  logic [AW-1:0] in_rsb,
  input  logic [DW-1:0] in_imm,
  input  logic          stall,
  output logic [AW-1:0] rdAddrA,
  input  logic [DW-1:0] rdDataA,
  output logic [AW-1:0] rdAddrB,
  input  logic [DW-1:0] rdDataB,
  output logic          write,
  output logic [AW-1:0] wrAddr,
  output logic [DW-1:0] wrData,
  output logic          carry,
  output logic          zero,
  output logic [15:0]   retired
);
  localparam logic [AW:0] NREG_C = (AW+1)'(NREG);

  typedef struct packed {
    logic          vld;
    logic [2:0]    op;
    logic [AW-1:0] rd;
    logic [DW-1:0] imm;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } s1_t;

  s1_t           s1_q, s1_d;
  logic          write_q, write_d;
  logic [AW-1:0] wraddr_q, wraddr_d;
  logic [DW-1:0] wrdata_q, wrdata_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;
  logic [15:0]   retired_q, retired_d;

  logic          accept;
  logic [DW-1:0] fwd_a, fwd_b;
  logic [DW-1:0] alu_res;
  logic          alu_carry;

  function automatic logic in_range(input logic [AW-1:0] r);
    return {1'b0, r} < NREG_C;
  endfunction

  // Youngest producer wins: S1 result, then the pending WB write, then the file itself.
  function automatic logic [DW-1:0] fwd_sel(
    input logic [AW-1:0] src,
    input logic [DW-1:0] file_dat,
    input logic          s1_vld,
    input logic [AW-1:0] s1_rd,
    input logic [DW-1:0] s1_res,
    input logic          wb_wr,
    input logic [AW-1:0] wb_addr,
    input logic [DW-1:0] wb_dat
  );
    if (!in_range(src)) return '0;
    if (s1_vld && (s1_rd == src) && in_range(s1_rd)) return s1_res;
    if (wb_wr && (wb_addr == src)) return wb_dat;
    return file_dat;
  endfunction

  assign in_ready = !stall;
  assign accept   = in_valid && !stall;
  assign rdAddrA  = in_rsa;
  assign rdAddrB  = in_rsb;

  assign fwd_a = fwd_sel(in_rsa, rdDataA, s1_q.vld, s1_q.rd, alu_res, write_q, wraddr_q, wrdata_q);
  assign fwd_b = fwd_sel(in_rsb, rdDataB, s1_q.vld, s1_q.rd, alu_res, write_q, wraddr_q, wrdata_q);

  rf_alu #(.DW(DW)) u_alu (
    .op_i    (s1_q.op),
    .a_i     (s1_q.a),
    .b_i     (s1_q.b),
    .imm_i   (s1_q.imm),
    .result_o(alu_res),
    .carry_o (alu_carry)
  );

  always_comb begin
    s1_d     = s1_q;
    s1_d.vld = accept;
    if (accept) begin
      s1_d.op  = in_op;
      s1_d.rd  = in_rd;
      s1_d.imm = in_imm;
      s1_d.a   = fwd_a;
      s1_d.b   = fwd_b;
    end
  end

  // Out-of-range destinations still retire and set zero; they just never write the file.
  always_comb begin
    write_d   = s1_q.vld && in_range(s1_q.rd);
    wraddr_d  = wraddr_q;
    wrdata_d  = wrdata_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    retired_d = retired_q;
    if (s1_q.vld) begin
      wraddr_d  = s1_q.rd;
      wrdata_d  = alu_res;
      zero_d    = (alu_res == '0);
      retired_d = retired_q + 16'd1;
      if (is_arith(s1_q.op)) carry_d = alu_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      write_q   <= 1'b0;
      wraddr_q  <= '0;
      wrdata_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      s1_q      <= s1_d;
      write_q   <= write_d;
      wraddr_q  <= wraddr_d;
      wrdata_q  <= wrdata_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      retired_q <= retired_d;
    end
  end

  assign write   = write_q;
  assign wrAddr  = wraddr_q;
  assign wrData  = wrdata_q;
  assign carry   = carry_q;
  assign zero    = zero_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_rf_exec_stage.sv
// Scoreboard bench for rf_exec_stage with a behavioural 4x16 register file on its ports.
module tb_rf_exec_stage;
  import rf_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [2:0]  in_rd, in_rsa, in_rsb;
  logic [15:0] in_imm;
  logic        stall;
  logic [2:0]  rdAddrA, rdAddrB;
  logic [15:0] rdDataA, rdDataB;
  logic        write;
  logic [2:0]  wrAddr;
  logic [15:0] wrData;
  logic        carry, zero;
  logic [15:0] retired;

  rf_exec_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rsa(in_rsa), .in_rsb(in_rsb), .in_imm(in_imm),
    .stall(stall), .rdAddrA(rdAddrA), .rdDataA(rdDataA), .rdAddrB(rdAddrB), .rdDataB(rdDataB),
    .write(write), .wrAddr(wrAddr), .wrData(wrData), .carry(carry), .zero(zero),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] rf_mem [0:3];
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 4; i++) rf_mem[i] <= 16'h0;
    end else if (write && (wrAddr < 3'd4)) begin
      rf_mem[wrAddr[1:0]] <= wrData;
    end
  end
  assign rdDataA = (rdAddrA < 3'd4) ? rf_mem[rdAddrA[1:0]] : 16'h0;
  assign rdDataB = (rdAddrB < 3'd4) ? rf_mem[rdAddrB[1:0]] : 16'h0;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] dat;
    logic        c;
    logic        z;
    logic [15:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  logic [15:0] exp_ret = 16'h0;
  logic [15:0] prev_ret = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic instr_t mk(input logic [2:0] op, input logic [2:0] rd,
                                input logic [2:0] rsa, input logic [2:0] rsb,
                                input logic [15:0] imm);
    instr_t t;
    t.op = op; t.rd = rd; t.rsa = rsa; t.rsb = rsb; t.imm = imm;
    return t;
  endfunction

  task automatic issue(input instr_t ins, input logic [15:0] dat, input logic c, input logic z);
    exp_t e;
    @(posedge clk); #2;
    stall    = 1'b0;
    in_valid = 1'b1;
    in_op    = ins.op;
    in_rd    = ins.rd;
    in_rsa   = ins.rsa;
    in_rsb   = ins.rsb;
    in_imm   = ins.imm;
    exp_ret  = exp_ret + 16'd1;
    e.cyc  = cyc + 2;
    e.wr   = (ins.rd < 3'd4);
    e.addr = ins.rd;
    e.dat  = dat;
    e.c    = c;
    e.z    = z;
    e.ret  = exp_ret;
    sb.push_back(e);
  endtask

  task automatic bubble(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      in_valid = 1'b0;
    end
  endtask

  // Monitor: a change of retired marks each retirement; pop and compare the WB-cycle outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ret = 16'h0;
      end else begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
          e = sb.pop_front();
          checks++;
          $display("FAIL retire_timeout: no retirement seen, expected at cycle %0d (now %0d)", e.cyc, cyc);
        end
        if (retired !== prev_ret) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_retire: retired=%0h with nothing outstanding", retired);
          end else begin
            e = sb.pop_front();
            chk("ret_cycle", cyc, e.cyc);
            chk("retired", {16'h0, retired}, {16'h0, e.ret});
            chk("write", {31'h0, write}, {31'h0, e.wr});
            if (e.wr) begin
              chk("wrAddr", {29'h0, wrAddr}, {29'h0, e.addr});
              chk("wrData", {16'h0, wrData}, {16'h0, e.dat});
            end
            chk("carry", {31'h0, carry}, {31'h0, e.c});
            chk("zero", {31'h0, zero}, {31'h0, e.z});
          end
          prev_ret = retired;
        end else if (write !== 1'b0) begin
          checks++;
          $display("FAIL spurious_write: write=%b addr=%0h data=%0h with no retirement", write, wrAddr, wrData);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0;
    in_op = 3'd0; in_rd = 3'd0; in_rsa = 3'd0; in_rsb = 3'd0; in_imm = 16'h0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_write", {31'h0, write}, 32'h0);
    chk("rst_wrAddr", {29'h0, wrAddr}, 32'h0);
    chk("rst_wrData", {16'h0, wrData}, 32'h0);
    chk("rst_carry", {31'h0, carry}, 32'h0);
    chk("rst_zero", {31'h0, zero}, 32'h0);
    chk("rst_retired", {16'h0, retired}, 32'h0);
    chk("rst_ready", {31'h0, in_ready}, 32'h1);
    stall = 1'b1; #1;
    chk("rst_ready_stall", {31'h0, in_ready}, 32'h0);
    stall = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;

    issue(mk(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h1234), 16'h1234, 1'b0, 1'b0);
    // Same ADD with r0=5 produced 0, 1 and 2 cycles earlier: S1, WB and file paths.
    issue(mk(OP_LDI, 3'd0, 3'd0, 3'd0, 16'h0005), 16'h0005, 1'b0, 1'b0);
    issue(mk(OP_ADD, 3'd2, 3'd0, 3'd0, 16'h0000), 16'h000A, 1'b0, 1'b0);
    bubble(2);
    issue(mk(OP_LDI, 3'd0, 3'd0, 3'd0, 16'h0000), 16'h0000, 1'b0, 1'b1);
    bubble(2);
    issue(mk(OP_LDI, 3'd0, 3'd0, 3'd0, 16'h0005), 16'h0005, 1'b0, 1'b0);
    bubble(1);
    issue(mk(OP_ADD, 3'd2, 3'd0, 3'd0, 16'h0000), 16'h000A, 1'b0, 1'b0);
    issue(mk(OP_LDI, 3'd0, 3'd0, 3'd0, 16'h0000), 16'h0000, 1'b0, 1'b1);
    bubble(2);
    issue(mk(OP_LDI, 3'd0, 3'd0, 3'd0, 16'h0005), 16'h0005, 1'b0, 1'b0);
    bubble(2);
    issue(mk(OP_ADD, 3'd2, 3'd0, 3'd0, 16'h0000), 16'h000A, 1'b0, 1'b0);

    issue(mk(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h0001), 16'h0001, 1'b0, 1'b0);
    issue(mk(OP_LDI, 3'd0, 3'd0, 3'd0, 16'h0000), 16'h0000, 1'b0, 1'b1);
    issue(mk(OP_SUB, 3'd3, 3'd0, 3'd1, 16'h0000), 16'hFFFF, 1'b1, 1'b0);
    issue(mk(OP_XOR, 3'd3, 3'd3, 3'd3, 16'h0000), 16'h0000, 1'b1, 1'b1);
    issue(mk(OP_ADD, 3'd3, 3'd1, 3'd1, 16'h0000), 16'h0002, 1'b0, 1'b0);
    issue(mk(OP_LDI, 3'd2, 3'd0, 3'd0, 16'h8421), 16'h8421, 1'b0, 1'b0);
    issue(mk(OP_SHL, 3'd3, 3'd2, 3'd1, 16'h0000), 16'h0842, 1'b0, 1'b0);
    issue(mk(OP_SHR, 3'd3, 3'd2, 3'd1, 16'h0000), 16'h4210, 1'b0, 1'b0);
    issue(mk(OP_AND, 3'd3, 3'd2, 3'd1, 16'h0000), 16'h0001, 1'b0, 1'b0);
    issue(mk(OP_OR,  3'd0, 3'd2, 3'd1, 16'h0000), 16'h8421, 1'b0, 1'b0);
    issue(mk(OP_ADD, 3'd3, 3'd0, 3'd0, 16'h0000), 16'h0842, 1'b1, 1'b0);

    issue(mk(OP_LDI, 3'd5, 3'd0, 3'd0, 16'h00FF), 16'h00FF, 1'b1, 1'b0);
    issue(mk(OP_ADD, 3'd0, 3'd5, 3'd5, 16'h0000), 16'h0000, 1'b0, 1'b1);

    issue(mk(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h0077), 16'h0077, 1'b0, 1'b0);
    issue(mk(OP_LDI, 3'd2, 3'd0, 3'd0, 16'h0088), 16'h0088, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #2;
      stall = 1'b1; in_valid = 1'b1;
      in_op = OP_LDI; in_rd = 3'd3; in_imm = 16'hDEAD;
      #1;
      chk("stall_ready", {31'h0, in_ready}, 32'h0);
    end
    issue(mk(OP_LDI, 3'd3, 3'd0, 3'd0, 16'hBEEF), 16'hBEEF, 1'b0, 1'b0);
    #1;
    chk("release_ready", {31'h0, in_ready}, 32'h1);

    issue(mk(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h1111), 16'h1111, 1'b0, 1'b0);
    issue(mk(OP_LDI, 3'd2, 3'd0, 3'd0, 16'h2222), 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #2;
    in_op = OP_LDI; in_rd = 3'd0; in_imm = 16'h5A5A;
    rst_n = 1'b0;
    sb.delete();
    exp_ret = 16'h0;
    #1;
    chk("mid_rst_write", {31'h0, write}, 32'h0);
    chk("mid_rst_carry", {31'h0, carry}, 32'h0);
    chk("mid_rst_zero", {31'h0, zero}, 32'h0);
    chk("mid_rst_retired", {16'h0, retired}, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #2;
      chk("post_rst_write", {31'h0, write}, 32'h0);
    end
    issue(mk(OP_LDI, 3'd0, 3'd0, 3'd0, 16'h0042), 16'h0042, 1'b0, 1'b0);
    bubble(4);
    chk("sb_drained", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
